// File: rtl/stack_ctrl.sv
`timescale 1ns/1ps
// stack_ctrl: game-state controller for the stacking game, sitting directly
// upstream of the VGA renderer. It owns the stack contents, sweeps the
// falling block left and right, drops it on a button press and judges each
// landing against the stack x position.
//
// Ports:
//   clk, rst_n  - system clock; asynchronous active-low reset
//   tick        - one-cycle game-tick strobe; all movement steps on it
//   btn_drop    - debounced, synchronous button level (edge-detected here)
//   pos_x/pos_y - stack left x / y of layer 0 (constant after reset)
//   colors      - 16 layers x 2 bits; layer i is in [2i+1:2i], 00 = empty
//   fall_x/_y   - falling block position
//   fall_clr    - falling block colour, 00 = hidden
//   score       - successful landings, saturating
//   game_over   - set on a miss (or on a full stack in non-scroll builds)
//
// Build option: STACK_SCROLL_EN - when defined, a hit on the top layer
// scrolls the stack down by one layer instead of ending the game.
module stack_ctrl #(
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 20,
  parameter int POS_X      = 272,
  parameter int POS_Y      = 400,
  parameter int TOP_Y      = 20,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 640,
  parameter int SWEEP_STEP = 4,
  parameter int FALL_STEP  = 4,
  parameter int TOL        = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        btn_drop,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic [31:0] colors,
  output logic [9:0]  fall_x,
  output logic [9:0]  fall_y,
  output logic [1:0]  fall_clr,
  output logic [15:0] score,
  output logic        game_over
);

  typedef enum logic [2:0] {IDLE, SWEEP, DROP, LAND, OVER} state_t;

  // Falling block as one bundle so respawn/restart assign it in one go.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] clr;
  } blk_t;

  localparam logic [9:0]  X_LO   = 10'(X_MIN);
  localparam logic [9:0]  Y_TOP  = 10'(TOP_Y);
  localparam logic [10:0] X_RLIM = 11'(X_MAX - WIDTH);
  localparam logic [10:0] X_LLIM = 11'(X_MIN + SWEEP_STEP);
  localparam logic [10:0] SW_ST  = 11'(SWEEP_STEP);
  localparam logic [10:0] FL_ST  = 11'(FALL_STEP);
  localparam logic [9:0]  TOL_V  = 10'(TOL);

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic        dir, dir_n;      // 0 = moving right, 1 = moving left
  logic        btn_q;
  logic        press;
  blk_t        blk, blk_n;
  logic [31:0] colors_n;
  logic [15:0] score_n;
  logic        go_n;

  logic [9:0]  land_y;
  logic [9:0]  dx;
  logic        hit;
  logic [1:0]  clr_rot;
  logic [4:0]  sh;
  logic [31:0] colors_wr;
  logic [15:0] score_inc;

  assign press     = btn_drop & ~btn_q;
  assign land_y    = 10'(POS_Y) - 10'(10'(cnt) * 10'(HEIGHT));
  // Larger operand first keeps the unsigned difference from wrapping.
  assign dx        = (blk.x >= pos_x) ? (blk.x - pos_x) : (pos_x - blk.x);
  assign hit       = (dx <= TOL_V);
  assign clr_rot   = (blk.clr == 2'b11) ? 2'b01 : (blk.clr + 2'b01);
  assign sh        = {cnt[3:0], 1'b0};
  assign colors_wr = (colors & ~(32'h3 << sh)) | (32'(blk.clr) << sh);
  assign score_inc = (score == 16'hFFFF) ? score : (score + 16'd1);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dir_n    = dir;
    blk_n    = blk;
    colors_n = colors;
    score_n  = score;
    go_n     = game_over;
    case (state)
      IDLE: if (press) begin
        blk_n.clr = 2'b01;
        state_n   = SWEEP;
      end
      SWEEP: begin
        // A press on the same cycle as a tick freezes x and drops from there.
        if (press) state_n = DROP;
        else if (tick) begin
          if (!dir) begin
            if ({1'b0, blk.x} + SW_ST >= X_RLIM) begin
              blk_n.x = X_RLIM[9:0];
              dir_n   = 1'b1;
            end else blk_n.x = blk.x + SW_ST[9:0];
          end else begin
            if ({1'b0, blk.x} <= X_LLIM) begin
              blk_n.x = X_LO;
              dir_n   = 1'b0;
            end else blk_n.x = blk.x - SW_ST[9:0];
          end
        end
      end
      DROP: if (tick) begin
        if ({1'b0, blk.y} + FL_ST >= {1'b0, land_y}) begin
          blk_n.y = land_y;
          state_n = LAND;
        end else blk_n.y = blk.y + FL_ST[9:0];
      end
      LAND: begin
        if (!hit) begin
          go_n    = 1'b1;
          state_n = OVER;
        end else begin
          score_n = score_inc;
          blk_n   = '{x: X_LO, y: Y_TOP, clr: clr_rot};
          dir_n   = 1'b0;
          state_n = SWEEP;
          if (cnt < 5'd15) begin
            colors_n = colors_wr;
            cnt_n    = cnt + 5'd1;
          end else begin
`ifdef STACK_SCROLL_EN
            colors_n = {blk.clr, colors[31:2]};
`else
            // Full stack: write the top layer and end the game in place.
            colors_n = colors_wr;
            blk_n    = blk;
            dir_n    = dir;
            go_n     = 1'b1;
            state_n  = OVER;
`endif
          end
        end
      end
      OVER: if (press) begin
        colors_n = '0;
        cnt_n    = '0;
        score_n  = '0;
        go_n     = 1'b0;
        blk_n    = '{x: X_LO, y: Y_TOP, clr: 2'b01};
        dir_n    = 1'b0;
        state_n  = SWEEP;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dir       <= 1'b0;
      btn_q     <= 1'b0;
      blk       <= '{x: X_LO, y: Y_TOP, clr: 2'b00};
      colors    <= '0;
      score     <= '0;
      game_over <= 1'b0;
      pos_x     <= 10'(POS_X);
      pos_y     <= 10'(POS_Y);
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dir       <= dir_n;
      btn_q     <= btn_drop;
      blk       <= blk_n;
      colors    <= colors_n;
      score     <= score_n;
      game_over <= go_n;
    end
  end

  assign fall_x   = blk.x;
  assign fall_y   = blk.y;
  assign fall_clr = blk.clr;

endmodule

// File: tb/tb_stack_ctrl.sv
`timescale 1ns/1ps
module tb_stack_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        btn_drop = 1'b0;
  logic [9:0]  pos_x, pos_y, fall_x, fall_y;
  logic [31:0] colors;
  logic [1:0]  fall_clr;
  logic [15:0] score;
  logic        game_over;

  stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_drop(btn_drop),
    .pos_x(pos_x), .pos_y(pos_y), .colors(colors),
    .fall_x(fall_x), .fall_y(fall_y), .fall_clr(fall_clr),
    .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [9:0]  fx, fy;
    logic [1:0]  clr;
    logic [31:0] colors;
    logic [15:0] score;
    logic        go;
  } exp_t;

  typedef struct {
    logic       t, b;
    logic [9:0] fx, fy;
    logic [1:0] clr;
  } vec_t;

`ifdef STACK_SCROLL_EN
  localparam int NL = 17;
`else
  localparam int NL = 16;
`endif

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] e_colors = '0;
  logic [15:0] e_score = '0;
  logic        e_go = 1'b0;

  task automatic step(input logic t, input logic b);
    tick = t; btn_drop = b;
    @(posedge clk); #1;
  endtask

  task automatic push(input string nm, input logic [9:0] fx, input logic [9:0] fy,
                      input logic [1:0] clr);
    exp_t e;
    e.name = nm; e.fx = fx; e.fy = fy; e.clr = clr;
    e.colors = e_colors; e.score = e_score; e.go = e_go;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (pos_x === 10'd272 && pos_y === 10'd400 && fall_x === e.fx && fall_y === e.fy &&
        fall_clr === e.clr && colors === e.colors && score === e.score && game_over === e.go)
      n_pass++;
    else
      $display("FAIL %s: got pos=%0d,%0d fx=%0d fy=%0d clr=%0d colors=%h score=%0d go=%0b; want pos=272,400 fx=%0d fy=%0d clr=%0d colors=%h score=%0d go=%0b",
               e.name, pos_x, pos_y, fall_x, fall_y, fall_clr, colors, score, game_over,
               e.fx, e.fy, e.clr, e.colors, e.score, e.go);
  endtask

  task automatic expect_now(input string nm, input logic [9:0] fx, input logic [9:0] fy,
                            input logic [1:0] clr);
    push(nm, fx, fy, clr);
    pop_check();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tv[8];
    logic [1:0] c;
    logic [1:0] rot;
    int         ly;

    tv[0] = '{1'b0, 1'b0, 10'd0,  10'd20, 2'd0};  // idle, no press
    tv[1] = '{1'b0, 1'b1, 10'd0,  10'd20, 2'd1};  // press -> sweep
    tv[2] = '{1'b1, 1'b1, 10'd4,  10'd20, 2'd1};  // held, tick moves
    tv[3] = '{1'b1, 1'b1, 10'd8,  10'd20, 2'd1};  // still held: no second press
    tv[4] = '{1'b0, 1'b0, 10'd8,  10'd20, 2'd1};  // no tick, no move
    tv[5] = '{1'b1, 1'b0, 10'd12, 10'd20, 2'd1};
    tv[6] = '{1'b1, 1'b0, 10'd16, 10'd20, 2'd1};
    tv[7] = '{1'b1, 1'b0, 10'd20, 10'd20, 2'd1};  // 5 ticks -> 20

    repeat (2) @(posedge clk);
    #1;
    expect_now("reset", 10'd0, 10'd20, 2'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      push($sformatf("vec%0d", i), tv[i].fx, tv[i].fy, tv[i].clr);
      step(tv[i].t, tv[i].b);
      pop_check();
    end

    // Right edge clamp and reversal
    repeat (129) step(1'b1, 1'b0);
    expect_now("before_edge", 10'd536, 10'd20, 2'd1);
    step(1'b1, 1'b0);
    expect_now("right_edge", 10'd540, 10'd20, 2'd1);
    step(1'b1, 1'b0);
    expect_now("turn_left", 10'd536, 10'd20, 2'd1);

    // Aligned landing at x=272
    repeat (66) step(1'b1, 1'b0);
    expect_now("sweep_272", 10'd272, 10'd20, 2'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (94) step(1'b1, 1'b0);
    expect_now("drop_396", 10'd272, 10'd396, 2'd1);
    step(1'b1, 1'b0);
    expect_now("landed", 10'd272, 10'd400, 2'd1);
    step(1'b0, 1'b0);
    e_colors = 32'h1; e_score = 16'd1;
    expect_now("respawn", 10'd0, 10'd20, 2'd2);

    // Miss at x=284
    repeat (71) step(1'b1, 1'b0);
    expect_now("sweep_284", 10'd284, 10'd20, 2'd2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (90) step(1'b1, 1'b0);
    expect_now("drop_380", 10'd284, 10'd380, 2'd2);
    step(1'b0, 1'b0);
    e_go = 1'b1;
    expect_now("miss_over", 10'd284, 10'd380, 2'd2);
    step(1'b1, 1'b0);
    expect_now("over_hold", 10'd284, 10'd380, 2'd2);
    step(1'b0, 1'b1);
    e_colors = '0; e_score = '0; e_go = 1'b0;
    expect_now("restart", 10'd0, 10'd20, 2'd1);
    step(1'b1, 1'b0);
    expect_now("resume", 10'd4, 10'd20, 2'd1);

    // Press coinciding with tick, then held for 100 cycles
    step(1'b1, 1'b1);
    expect_now("coincide", 10'd4, 10'd20, 2'd1);
    step(1'b1, 1'b1);
    expect_now("drop_after_coincide", 10'd4, 10'd24, 2'd1);
    repeat (94) step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    e_go = 1'b1;
    expect_now("held_single", 10'd4, 10'd400, 2'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    e_go = 1'b0;
    expect_now("restart2", 10'd0, 10'd20, 2'd1);
    step(1'b0, 1'b0);

    // Stack build-up
    for (int k = 0; k < NL; k++) begin
      c  = 2'((k % 3) + 1);
      ly = 400 - 20 * ((k > 15) ? 15 : k);
      repeat (68) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      repeat ((ly - 20) / 4) step(1'b1, 1'b0);
      expect_now($sformatf("land%0d_y", k), 10'd272, 10'(ly), c);
      if (k < 15) e_colors[2*k +: 2] = c;
      else begin
`ifdef STACK_SCROLL_EN
        e_colors = {c, e_colors[31:2]};
`else
        e_colors[31:30] = c;
`endif
      end
      e_score = e_score + 16'd1;
      step(1'b0, 1'b0);
      rot = (c == 2'd3) ? 2'd1 : c + 2'd1;
`ifndef STACK_SCROLL_EN
      if (k == 15) begin
        e_go = 1'b1;
        expect_now("stack_full", 10'd272, 10'(ly), c);
      end else
`endif
        expect_now($sformatf("land%0d_done", k), 10'd0, 10'd20, rot);
    end

    // Asynchronous reset mid-operation
    step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    e_colors = '0; e_score = '0; e_go = 1'b0;
    expect_now("async_reset", 10'd0, 10'd20, 2'd0);
    step(1'b1, 1'b1);
    expect_now("reset_held", 10'd0, 10'd20, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
